if_fetch: RTL and testbench

Instruction-fetch stage of the RISC-V core, directly upstream of the decode stage. Holds the PC and issues word-aligned fetch requests to instruction memory over a valid/ready channel, with up to DEPTH requests in flight. Buffers in-order responses in a small queue and presents instruction/PC pairs to decode over a valid/ready handshake. Handles control-flow redirects from execute by flushing the queue and discarding stale in-flight responses.

---
 rtl/if_fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/if_fetch.sv | 146 ++++++++++++++
 tb/tb_if_fetch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared core package for the instruction-fetch stage.
// Provides the data width, the canonical NOP encoding, the default reset PC
// and the {instr, pc} entry carried from fetch to decode.
package if_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with show-ahead head output.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   push, din    write an entry (accepted when not full, or when popping)
//   pop          remove the head entry (ignored when empty)
//   flush        discard all entries; takes priority over push/pop
//   dout         current head entry (undefined when empty)
//   empty, full  occupancy flags
//   count        number of stored entries, 0..DEPTH
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign count = count_reg;
    assign dout  = mem[rd_ptr_reg];

    assign do_pop  = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    // Storage has no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage.
// Holds the PC, issues word-aligned requests to instruction memory with at
// most DEPTH requests in flight, buffers in-order responses and hands
// {instr, pc} pairs to decode. A redirect from execute reloads the PC,
// flushes the queue and marks every in-flight response as stale.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   imem_req_valid/ready/addr       fetch request channel
//   imem_rsp_valid/data             in-order response, no backpressure
//   redirect_valid/pc               taken branch/jump from execute
//   instr_valid/ready, instr,
//   instr_pc                        decode handshake and payload
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = $bits(fetch_entry_t);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   discard_reg;
    logic [CW-1:0]   discard_next;

    logic            credit_ok;
    logic            req_fire;
    logic            rsp_fire;

    logic [XLEN-1:0] tag_head;
    logic            tag_empty;
    logic            tag_full;
    logic [CW-1:0]   tag_count;

    fetch_entry_t    q_in;
    logic [EW-1:0]   q_head_bits;
    fetch_entry_t    q_head;
    logic            q_push;
    logic            q_pop;
    logic            q_empty;
    logic            q_full;
    logic [CW-1:0]   q_count;

    // Every request reserves a queue slot up front, so the queue never
    // has to refuse a response.
    assign credit_ok      = ({1'b0, outstanding_reg} + {1'b0, q_count}) < (CW + 1)'(DEPTH);
    assign imem_req_valid = !rst && !redirect_valid && credit_ok && !tag_full;
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;
    // A response with no recorded tag cannot belong to this stage; ignore it.
    assign rsp_fire       = imem_rsp_valid && !tag_empty;

    assign q_in.instr = imem_rsp_data;
    assign q_in.pc    = tag_head;
    assign q_pop      = !q_empty && instr_ready;
    assign q_push     = rsp_fire && (discard_reg == '0) && !redirect_valid && (!q_full || q_pop);
    assign q_head     = fetch_entry_t'(q_head_bits);

    assign instr_valid = !q_empty;
    assign instr       = q_empty ? INSTR_NOP : q_head.instr;
    assign instr_pc    = q_empty ? '0 : q_head.pc;

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .din   (pc_reg),
        .pop   (rsp_fire),
        .flush (1'b0),
        .dout  (tag_head),
        .empty (tag_empty),
        .full  (tag_full),
        .count (tag_count)
    );

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .din   (q_in),
        .pop   (q_pop),
        .flush (redirect_valid),
        .dout  (q_head_bits),
        .empty (q_empty),
        .full  (q_full),
        .count (q_count)
    );

    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_fire);
        discard_next     = discard_reg;

        if (redirect_valid) begin
            pc_next = redirect_pc & ~32'h3;
            // Every request still in flight after this cycle's response is
            // stale; the tag FIFO occupancy is exactly that in-flight count,
            // and it already includes any stale ones not yet returned.
            discard_next = tag_count - CW'(rsp_fire);
        end else begin
            if (req_fire) begin
                pc_next = pc_reg + 32'd4;
            end
            if (rsp_fire && (discard_reg != '0)) begin
                discard_next = discard_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    if_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    // Reference model: requests in flight (oldest first, with a stale flag),
    // the PCs decode should see in order, and the next PC to fetch.
    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } flight_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memr_t;

    flight_t     infl[$];
    logic [31:0] decq[$];
    logic [31:0] model_pc;
    memr_t       memq[$];
    logic [31:0] popped[$];
    int          cyc;
    int          lat;

    int          checks = 0;
    int          errors = 0;
    int          pop_cnt;
    int          req_cnt;
    logic [31:0] last_pc;
    logic [31:0] samp_addr;
    logic        samp_rv;
    logic        samp_iv;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs and the memory response, sample and
    // check outputs, then advance the reference model.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit iready, input bit mready);
        bit      exp_rv;
        bit      fire;
        flight_t e;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = iready;
        imem_req_ready = mready;
        if (memq.size() > 0 && memq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        exp_rv = !redir && ((infl.size() + decq.size()) < DEPTH);
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, decq.size() > 0});
        if (exp_rv) chk("req_addr", imem_req_addr, model_pc);
        samp_addr = imem_req_addr;
        samp_rv   = imem_req_valid;
        samp_iv   = instr_valid;
        if (decq.size() > 0) begin
            chk("instr_pc", instr_pc, decq[0]);
            chk("instr", instr, mem_data(decq[0]));
            if (iready) begin
                $display("decode xfer: pc=%h instr=%h", instr_pc, instr);
                pop_cnt++;
                last_pc = decq[0];
                popped.push_back(decq[0]);
                void'(decq.pop_front());
            end
        end
        if (imem_rsp_valid && infl.size() > 0) begin
            e = infl.pop_front();
            if (!e.stale && !redir) decq.push_back(e.pc);
        end
        if (redir) begin
            decq.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            model_pc = rpc & ~32'h3;
        end
        fire = imem_req_valid && mready;
        if (fire) begin
            infl.push_back('{pc: model_pc, stale: 1'b0});
            memq.push_back('{addr: imem_req_addr, due: cyc + lat});
            model_pc = model_pc + 32'd4;
            req_cnt++;
        end
        cyc++;
    endtask

    // Asynchronous reset between clock edges; outputs must react at once.
    // Memory shares the reset, so its pipeline is cleared too.
    task automatic do_reset(input int new_lat);
        @(negedge clk);
        #2;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_pc", instr_pc, 32'd0);
        infl.delete();
        decq.delete();
        memq.delete();
        popped.delete();
        model_pc = RESET_PC;
        lat      = new_lat;
        pop_cnt  = 0;
        req_cnt  = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((infl.size() > 0 || decq.size() > 0) && n < 40) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            n++;
        end
        if (infl.size() > 0 || decq.size() > 0) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } redir_vec_t;

    redir_vec_t vecs[6];

    initial begin
        vecs[0] = '{rpc: 32'h0000_0203, exp_addr: 32'h0000_0200, exp_next: 32'h0000_0204};
        vecs[1] = '{rpc: 32'h0000_0100, exp_addr: 32'h0000_0100, exp_next: 32'h0000_0104};
        vecs[2] = '{rpc: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};
        vecs[3] = '{rpc: 32'h0000_0006, exp_addr: 32'h0000_0004, exp_next: 32'h0000_0008};
        vecs[4] = '{rpc: 32'h8000_0001, exp_addr: 32'h8000_0000, exp_next: 32'h8000_0004};
        vecs[5] = '{rpc: 32'h1234_567A, exp_addr: 32'h1234_5678, exp_next: 32'h1234_567C};

        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        cyc            = 0;
        lat            = 1;
        model_pc       = RESET_PC;

        // Stream from reset with 1-cycle memory; nothing lost in flight.
        do_reset(1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("first_req_addr", samp_addr, RESET_PC);
        chk("first_req_valid", {31'b0, samp_rv}, 32'd1);
        repeat (30) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("stream_conserve", pop_cnt, req_cnt - infl.size() - decq.size());
        chk("stream_first_pc", popped[0], 32'h0);
        chk("stream_second_pc", popped[1], 32'h4);

        // Decode stall: two requests fill the credit, then the queue drains in order.
        do_reset(1);
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("stall_req_cnt", req_cnt, 2);
        chk("stall_req_low", {31'b0, samp_rv}, 32'd0);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stall_pop_cnt", pop_cnt, 2);
        chk("stall_last_pc", last_pc, 32'h4);

        // Redirect with two responses in flight on 3-cycle memory.
        do_reset(3);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("two_in_flight", infl.size(), 2);
        step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        popped.delete();
        for (int i = 0; i < 30 && popped.size() < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        if (popped.size() < 2) begin
            chk("redir_timeout", popped.size(), 2);
        end else begin
            chk("redir_first_pc", popped[0], 32'h0000_0100);
            chk("redir_second_pc", popped[1], 32'h0000_0104);
        end

        // Redirect, response and decode handshake all in one cycle.
        do_reset(1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0040, 1'b1, 1'b1);
        chk("simul_pop_cnt", pop_cnt, 1);
        chk("simul_popped_pc", last_pc, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("simul_queue_empty", {31'b0, samp_iv}, 32'd0);
        chk("simul_req_valid", {31'b0, samp_rv}, 32'd1);
        chk("simul_req_addr", samp_addr, 32'h0000_0040);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("simul_next_pc", last_pc, 32'h0000_0040);

        // Redirect target alignment and PC wrap, table-driven.
        do_reset(2);
        foreach (vecs[i]) begin
            drain();
            step(1'b1, vecs[i].rpc, 1'b1, 1'b0);
            step(1'b0, 32'h0, 1'b1, 1'b1);
            chk("tbl_redir_valid", {31'b0, samp_rv}, 32'd1);
            chk("tbl_redir_addr", samp_addr, vecs[i].exp_addr);
            step(1'b0, 32'h0, 1'b1, 1'b0);
            chk("tbl_next_addr", samp_addr, vecs[i].exp_next);
        end

        // Reset mid-fetch with one outstanding and one queued instruction.
        do_reset(3);
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("mid_in_flight", infl.size(), 1);
        chk("mid_queued", decq.size(), 1);
        do_reset(3);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("mid_restart_valid", {31'b0, samp_rv}, 32'd1);
        chk("mid_restart_addr", samp_addr, RESET_PC);

        // Randomised traffic against the reference model.
        for (int ph = 0; ph < 4; ph++) begin
            do_reset($urandom_range(1, 4));
            for (int n = 0; n < 700; n++) begin
                if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 4));
                step($urandom_range(0, 11) == 0, $urandom,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
